// File: rtl/inv_butterfly1_if.sv
// Stream bundle for the inverse butterfly: (ao, bo) in, (ai, bi, err) out,
// each side with its own valid/ready pair.
interface inv_butterfly1_if #(
   parameter int W = 15
);
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] ao;
   logic signed [W-1:0] bo;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] ai;
   logic signed [W-1:0] bi;
   logic                err;

   modport master (
      output in_valid, ao, bo, out_ready,
      input  in_ready, out_valid, ai, bi, err
   );

   modport slave (
      input  in_valid, ao, bo, out_ready,
      output in_ready, out_valid, ai, bi, err
   );
endinterface

// File: rtl/inv_butterfly1.sv
// Inverse radix-2 butterfly: recovers (ai, bi) from ao = ai+bi, bo = (ai-bi)<<SHIFT
// in a two-stage valid/ready pipeline, flagging words no forward butterfly can emit.
module inv_butterfly1 #(
   parameter int W     = 15,
   parameter int SHIFT = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   inv_butterfly1_if.slave  bus,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   logic                s1_valid_q, s1_valid_d;
   logic signed [W:0]   s1_s_q, s1_s_d;
   logic signed [W:0]   s1_d_q, s1_d_d;
   logic                s1_err_q, s1_err_d;

   logic                out_valid_q, out_valid_d;
   logic signed [W-1:0] ai_q, ai_d;
   logic signed [W-1:0] bi_q, bi_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

   logic                adv2;
   logic                adv1;
   logic signed [W-1:0] bo_sh;
   logic signed [W:0]   s_in;
   logic signed [W:0]   d_in;
   logic                lsb_err;
   logic                par_err;

   always_comb begin
      adv2    = !out_valid_q || bus.out_ready;
      adv1    = !s1_valid_q || adv2;
      bo_sh   = bus.bo >>> SHIFT;
      s_in    = {bus.ao[W-1], bus.ao};
      d_in    = {bo_sh[W-1], bo_sh};
      lsb_err = |bus.bo[SHIFT-1:0];
      par_err = s_in[0] ^ d_in[0];

      s1_valid_d  = s1_valid_q;
      s1_s_d      = s1_s_q;
      s1_d_d      = s1_d_q;
      s1_err_d    = s1_err_q;
      out_valid_d = out_valid_q;
      ai_d        = ai_q;
      bi_d        = bi_q;
      err_d       = err_q;
      err_cnt_d   = err_cnt_q;

      if (adv1) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_s_d   = s_in;
            s1_d_d   = d_in;
            s1_err_d = lsb_err | par_err;
         end
      end

      // W+2-bit sum/difference cannot overflow; the halving drops the parity bit
      if (adv2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            ai_d  = W'(($signed({s1_s_q[W], s1_s_q}) + $signed({s1_d_q[W], s1_d_q})) >>> 1);
            bi_d  = W'(($signed({s1_s_q[W], s1_s_q}) - $signed({s1_d_q[W], s1_d_q})) >>> 1);
            err_d = s1_err_q;
         end
      end

      if (clr_cnt) begin
         err_cnt_d = '0;
      end else if (out_valid_q && bus.out_ready && err_q && !(&err_cnt_q)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_s_q      <= '0;
         s1_d_q      <= '0;
         s1_err_q    <= 1'b0;
         out_valid_q <= 1'b0;
         ai_q        <= '0;
         bi_q        <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_s_q      <= s1_s_d;
         s1_d_q      <= s1_d_d;
         s1_err_q    <= s1_err_d;
         out_valid_q <= out_valid_d;
         ai_q        <= ai_d;
         bi_q        <= bi_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.in_ready  = adv1;
   assign bus.out_valid = out_valid_q;
   assign bus.ai        = ai_q;
   assign bus.bi        = bi_q;
   assign bus.err       = err_q;
   assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_inv_butterfly1.sv
// Scoreboard bench for inv_butterfly1: an arithmetic reference model feeds an
// expected-output queue that a negedge monitor drains and compares.
module tb_inv_butterfly1;
   localparam int W     = 15;
   localparam int SHIFT = 2;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr_cnt = 1'b0;
   logic [CNT_W-1:0] err_cnt;

   inv_butterfly1_if #(.W(W)) bus();

   inv_butterfly1 #(.W(W), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .clr_cnt (clr_cnt),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ai;
      int bi;
      int err;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cnt_m  = 0;
   bit   hold   = 0;
   int   h_ai, h_bi, h_err;
   bit   saw_stall_ready_low = 0;
   bit   rnd_run = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int floor_div(int n, int m);
      int r;
      r = n / m;
      if ((n % m != 0) && (n < 0)) r = r - 1;
      return r;
   endfunction

   function automatic int wrap(int v);
      logic signed [W-1:0] t;
      t = W'(v);
      return int'(t);
   endfunction

   // ai+bi = ao and ai-bi = bo / 2^SHIFT; halving an odd total means a bad word
   function automatic exp_t model(int a, int b);
      exp_t e;
      int   d, s, df;
      d     = floor_div(b, 1 << SHIFT);
      s     = a + d;
      df    = a - d;
      e.err = ((b - d * (1 << SHIFT)) != 0 || (s % 2) != 0) ? 1 : 0;
      e.ai  = wrap(floor_div(s, 2));
      e.bi  = wrap(floor_div(df, 2));
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         cnt_m = 0;
         hold  = 0;
      end else begin
         chk("err_cnt", int'(err_cnt), cnt_m);
         if (hold) begin
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_ai", int'(bus.ai), h_ai);
            chk("stall_bi", int'(bus.bi), h_bi);
            chk("stall_err", int'(bus.err), h_err);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               chk("ai", int'(bus.ai), e.ai);
               chk("bi", int'(bus.bi), e.bi);
               chk("err", int'(bus.err), e.err);
               if (e.err != 0 && cnt_m < CMAX) cnt_m++;
            end
         end
         if (clr_cnt) cnt_m = 0;
         hold  = bus.out_valid && !bus.out_ready;
         h_ai  = int'(bus.ai);
         h_bi  = int'(bus.bi);
         h_err = int'(bus.err);
         if (bus.in_valid && !bus.in_ready) saw_stall_ready_low = 1;
      end
   end

   task automatic send(int a, int b);
      int n;
      bit done;
      n    = 0;
      done = 0;
      bus.in_valid = 1'b1;
      bus.ao       = W'(a);
      bus.bo       = W'(b);
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            q.push_back(model(a, b));
            done = 1;
         end
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 500) begin
            chk("send_timeout", 0, 1);
            done = 1;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || bus.out_valid) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= 3000) chk("drain_timeout", 0, 1);
   endtask

   function automatic int rnd_w();
      logic signed [W-1:0] t;
      t = W'($urandom);
      return int'(t);
   endfunction

   initial begin
      int n;
      bus.in_valid  = 1'b0;
      bus.ao        = '0;
      bus.bo        = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_ai", int'(bus.ai), 0);
      chk("rst_bi", int'(bus.bi), 0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", int'(bus.in_ready), 1);

      // basic word and two-cycle latency
      send(130, 280);
      chk("lat_not_early", int'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      chk("lat_valid", int'(bus.out_valid), 1);
      chk("t1_ai", int'(bus.ai), 100);
      chk("t1_bi", int'(bus.bi), 30);
      chk("t1_err", int'(bus.err), 0);
      drain();

      send(-30, -280);
      @(posedge clk);
      #1;
      chk("t2_ai", int'(bus.ai), -50);
      chk("t2_bi", int'(bus.bi), 20);
      drain();

      send(130, 281);
      send(131, 280);
      drain();
      chk("t3_err_cnt", int'(err_cnt), 2);

      // back-to-back with a three-cycle output stall
      saw_stall_ready_low = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) send(i * 37 - 100, (i * 12 - 50) * 4);
         end
         begin
            for (int k = 0; k < 10; k++) begin
               bus.out_ready = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
               @(posedge clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("t4_in_ready_dropped", int'(saw_stall_ready_low), 1);

      // randomized traffic with random backpressure
      rnd_run = 1;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               int a, b;
               a = rnd_w();
               b = rnd_w();
               if ($urandom_range(0, 1) == 1) b = wrap(b & ~((1 << SHIFT) - 1));
               send(a, b);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rnd_run = 0;
         end
         begin
            while (rnd_run) begin
               bus.out_ready = ($urandom_range(0, 2) != 0);
               @(posedge clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // saturation then clear racing an erroneous handshake
      for (int i = 0; i < 300; i++) send(i, 4 * i + 1);
      drain();
      chk("t5_saturated", int'(err_cnt), CMAX);
      send(5, 1);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t5_wait_valid", int'(bus.out_valid), 1);
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
      chk("t5_cleared", int'(err_cnt), 0);
      drain();

      // reset with two words in flight
      send(1000, 400);
      send(-1000, -400);
      chk("t6_inflight", int'(bus.out_valid), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", int'(bus.out_valid), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(222, 88);
      @(posedge clk);
      #1;
      chk("t6_post_valid", int'(bus.out_valid), 1);
      chk("t6_post_ai", int'(bus.ai), 122);
      chk("t6_post_bi", int'(bus.bi), 100);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
